// File: rtl/mission_status_pkg.sv
// Shared types for the mission status generator:
// FSM states, unit zone codes and default timing constants.
package mission_status_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEEK,
        ST_FAULT,
        ST_CARRY,
        ST_DONE
    } mission_state_t;

    localparam logic [1:0] UNIT_NONE = 2'b00;
    localparam logic [1:0] UNIT_EU   = 2'b01;
    localparam logic [1:0] UNIT_CU   = 2'b10;
    localparam logic [1:0] UNIT_RU   = 2'b11;

    localparam int DEB_CYCLES_DEF = 3125;
    localparam int NODE_HOLD_DEF  = 3125;

endpackage

// File: rtl/sensor_debounce.sv
// Raw sensor conditioning: 2-flop synchroniser, debounce, rising-edge detect.
// Debounce filter is present only when STATUS_DEBOUNCE_EN is defined.
module sensor_debounce
    import mission_status_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk_3125KHz,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_q;

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef STATUS_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Any sample that agrees with the current level restarts the count.
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync2;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
`else
    logic unused_deb;

    assign unused_deb = (DEB_CYCLES != 0);
    assign level      = sync2;
`endif

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/status_event_gen.sv
// Mission status generator: sequences sensor and arm events into LED flags.
// Define STATUS_DEBOUNCE_EN to enable the sensor debounce filter.
module status_event_gen
    import mission_status_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int NODE_HOLD  = NODE_HOLD_DEF,
    parameter int MAX_FAULTS = 3
) (
    input  logic       clk_3125KHz,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] unit_sel,
    input  logic       fault_sense,
    input  logic       node_sense,
    input  logic       pick_done,
    input  logic       drop_done,
    output logic       fault_detect,
    output logic       block_picked,
    output logic       node_flag,
    output logic       object_drop,
    output logic       run_complete,
    output logic       EU_fault_flag,
    output logic       CU_fault_flag,
    output logic       RU_fault_flag,
    output logic [1:0] faults_serviced
);

    localparam int NW = $clog2(NODE_HOLD + 1);

    mission_state_t state;
    logic           fault_rise;
    logic           node_rise;
    logic [NW-1:0]  node_cnt;
    logic [1:0]     srv_next;

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_fault_deb (
        .clk_3125KHz (clk_3125KHz),
        .rst_n       (rst_n),
        .raw         (fault_sense),
        .rise        (fault_rise)
    );

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_node_deb (
        .clk_3125KHz (clk_3125KHz),
        .rst_n       (rst_n),
        .raw         (node_sense),
        .rise        (node_rise)
    );

    assign srv_next = faults_serviced + 2'd1;

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            fault_detect    <= 1'b0;
            block_picked    <= 1'b0;
            object_drop     <= 1'b0;
            run_complete    <= 1'b0;
            EU_fault_flag   <= 1'b0;
            CU_fault_flag   <= 1'b0;
            RU_fault_flag   <= 1'b0;
            faults_serviced <= 2'd0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) state <= ST_SEEK;
                end
                ST_SEEK: begin
                    // Unit is latched here; later zone changes are ignored.
                    if (fault_rise && unit_sel != UNIT_NONE) begin
                        state         <= ST_FAULT;
                        fault_detect  <= 1'b1;
                        object_drop   <= 1'b0;
                        EU_fault_flag <= (unit_sel == UNIT_EU);
                        CU_fault_flag <= (unit_sel == UNIT_CU);
                        RU_fault_flag <= (unit_sel == UNIT_RU);
                    end
                end
                ST_FAULT: begin
                    if (pick_done) begin
                        state        <= ST_CARRY;
                        fault_detect <= 1'b0;
                        block_picked <= 1'b1;
                    end
                end
                ST_CARRY: begin
                    if (drop_done) begin
                        block_picked    <= 1'b0;
                        EU_fault_flag   <= 1'b0;
                        CU_fault_flag   <= 1'b0;
                        RU_fault_flag   <= 1'b0;
                        faults_serviced <= srv_next;
                        if (srv_next == 2'(MAX_FAULTS)) begin
                            state        <= ST_DONE;
                            run_complete <= 1'b1;
                            object_drop  <= 1'b0;
                        end else begin
                            state       <= ST_SEEK;
                            object_drop <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state           <= ST_SEEK;
                        run_complete    <= 1'b0;
                        object_drop     <= 1'b0;
                        faults_serviced <= 2'd0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Retriggerable hold: each armed edge restarts the full window.
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            node_cnt  <= '0;
            node_flag <= 1'b0;
        end else if (node_rise && state != ST_IDLE) begin
            node_cnt  <= NW'(NODE_HOLD - 1);
            node_flag <= 1'b1;
        end else if (node_cnt != '0) begin
            node_cnt <= node_cnt - NW'(1);
        end else begin
            node_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_status_event_gen.sv
// Self-checking bench for status_event_gen against a behavioural mission model.
// Honours STATUS_DEBOUNCE_EN to select the expected sensor latency.
module tb_status_event_gen;

    localparam int DEB  = 4;
    localparam int NH   = 8;
    localparam int MAXF = 2;
`ifdef STATUS_DEBOUNCE_EN
    localparam int WS   = 2;
    localparam int WIN  = DEB;
`else
    localparam int WS   = 1;
    localparam int WIN  = 1;
`endif
    localparam int LAT  = WS + WIN + 1;
    localparam int QLEN = WS + WIN + 1;

    localparam int P_IDLE  = 0;
    localparam int P_SEEK  = 1;
    localparam int P_FAULT = 2;
    localparam int P_CARRY = 3;
    localparam int P_DONE  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] unit_sel;
    logic       fault_sense;
    logic       node_sense;
    logic       pick_done;
    logic       drop_done;
    logic       fault_detect;
    logic       block_picked;
    logic       node_flag;
    logic       object_drop;
    logic       run_complete;
    logic       EU_fault_flag;
    logic       CU_fault_flag;
    logic       RU_fault_flag;
    logic [1:0] faults_serviced;
    logic [9:0] obsv;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    int     edge_n;
    int     node_until;
    int     phase;
    int     srv;
    bit     m_fd, m_bp, m_od, m_rc;
    bit [2:0] m_u;
    bit     f_lvl, n_lvl, f_ev, n_ev;
    bit     fh[$];
    bit     nh[$];

    status_event_gen #(
        .DEB_CYCLES (DEB),
        .NODE_HOLD  (NH),
        .MAX_FAULTS (MAXF)
    ) dut (
        .clk_3125KHz     (clk),
        .rst_n           (rst_n),
        .start           (start),
        .unit_sel        (unit_sel),
        .fault_sense     (fault_sense),
        .node_sense      (node_sense),
        .pick_done       (pick_done),
        .drop_done       (drop_done),
        .fault_detect    (fault_detect),
        .block_picked    (block_picked),
        .node_flag       (node_flag),
        .object_drop     (object_drop),
        .run_complete    (run_complete),
        .EU_fault_flag   (EU_fault_flag),
        .CU_fault_flag   (CU_fault_flag),
        .RU_fault_flag   (RU_fault_flag),
        .faults_serviced (faults_serviced)
    );

    always #5 clk = ~clk;

    assign obsv = {fault_detect, block_picked, node_flag, object_drop,
                   run_complete, EU_fault_flag, CU_fault_flag,
                   RU_fault_flag, faults_serviced};

    function automatic logic [9:0] expv();
        return {m_fd, m_bp, (edge_n < node_until), m_od, m_rc, m_u, 2'(srv)};
    endfunction

    // Level changes once the last WIN delayed samples all disagree with it.
    function automatic bit next_level(input bit q[$], input bit cur);
        bit x;
        x = q[WS];
        for (int i = WS; i < WS + WIN; i++)
            if (q[i] != x) return cur;
        return x;
    endfunction

    task automatic model_reset();
        edge_n = 0; node_until = 0; phase = P_IDLE; srv = 0;
        m_fd = 0; m_bp = 0; m_od = 0; m_rc = 0; m_u = 3'b000;
        f_lvl = 0; n_lvl = 0; f_ev = 0; n_ev = 0;
        fh.delete(); nh.delete();
        for (int i = 0; i < QLEN; i++) begin
            fh.push_back(1'b0);
            nh.push_back(1'b0);
        end
    endtask

    task automatic model_edge();
        bit nl;
        edge_n++;
        if (n_ev && phase != P_IDLE) node_until = edge_n + NH;
        case (phase)
            P_IDLE: if (start) phase = P_SEEK;
            P_SEEK: if (f_ev && unit_sel != 2'b00) begin
                phase = P_FAULT; m_fd = 1; m_od = 0;
                m_u = (unit_sel == 2'b01) ? 3'b100 :
                      (unit_sel == 2'b10) ? 3'b010 : 3'b001;
            end
            P_FAULT: if (pick_done) begin
                phase = P_CARRY; m_fd = 0; m_bp = 1;
            end
            P_CARRY: if (drop_done) begin
                m_bp = 0; m_u = 3'b000; srv++;
                if (srv == MAXF) begin
                    phase = P_DONE; m_rc = 1; m_od = 0;
                end else begin
                    phase = P_SEEK; m_od = 1;
                end
            end
            P_DONE: if (start) begin
                phase = P_SEEK; m_rc = 0; m_od = 0; srv = 0;
            end
            default: phase = P_IDLE;
        endcase
        fh.push_front(fault_sense); void'(fh.pop_back());
        nh.push_front(node_sense);  void'(nh.pop_back());
        nl = next_level(fh, f_lvl); f_ev = nl & ~f_lvl; f_lvl = nl;
        nl = next_level(nh, n_lvl); n_ev = nl & ~n_lvl; n_lvl = nl;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        start = 0; pick_done = 0; drop_done = 0;
        fault_sense = 0; node_sense = 0; unit_sel = 2'b00;
        rst_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic raise_fault(input logic [1:0] u, input int len);
        unit_sel = u; fault_sense = 1;
        repeat (len) tick();
        fault_sense = 0;
        repeat (WS + WIN + 2) tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (obsv !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", obsv, 10'b0);
        end
        pick_done = 1; drop_done = 1; tick();
        pick_done = 0; drop_done = 0;
        raise_fault(2'b01, LAT + 2);
        n_cmp++;
        if (obsv !== 10'b0 || obsv !== expv()) begin
            n_fail++;
            $display("FAIL idle_ignores: got %b want %b", obsv, 10'b0);
        end
    endtask

    task automatic test_debounce_reject();
        bit want;
        do_reset();
        pulse_start();
        unit_sel = 2'b10; fault_sense = 1;
        repeat (3) tick();
        fault_sense = 0;
        repeat (12) tick();
        want = (3 >= WIN);
        n_cmp++;
        if (fault_detect !== want || obsv !== expv()) begin
            n_fail++;
            $display("FAIL short_glitch: got %b want fd=%b model %b",
                     obsv, want, expv());
        end
    endtask

    task automatic test_fault_accept();
        do_reset();
        pulse_start();
        unit_sel = 2'b10; fault_sense = 1;
        repeat (LAT - 1) tick();
        n_cmp++;
        if (fault_detect !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_early: got fd=%b want 0", fault_detect);
        end
        tick();
        n_cmp++;
        if ({fault_detect, EU_fault_flag, CU_fault_flag, RU_fault_flag} !== 4'b1010
            || obsv !== expv()) begin
            n_fail++;
            $display("FAIL accept_latency: got %b want fd/eu/cu/ru=1010",
                     obsv);
        end
        repeat (10 - LAT) tick();
        fault_sense = 0;
        unit_sel = 2'b01;
        repeat (4) tick();
        n_cmp++;
        if ({EU_fault_flag, CU_fault_flag, RU_fault_flag} !== 3'b010
            || obsv !== expv()) begin
            n_fail++;
            $display("FAIL unit_latched: got %b want cu only", obsv);
        end
    endtask

    task automatic test_full_mission();
        logic [1:0] u;
        do_reset();
        pulse_start();
        u = 2'($urandom_range(1, 3));
        raise_fault(u, LAT + 2);
        n_cmp++;
        if (fault_detect !== 1'b1 || obsv !== expv()) begin
            n_fail++;
            $display("FAIL m1_fault: got %b want %b", obsv, expv());
        end
        pick_done = 1; tick(); pick_done = 0;
        n_cmp++;
        if ({fault_detect, block_picked} !== 2'b01 || obsv !== expv()) begin
            n_fail++;
            $display("FAIL m1_pick: got %b want %b", obsv, expv());
        end
        repeat ($urandom_range(0, 5)) tick();
        drop_done = 1; tick(); drop_done = 0;
        n_cmp++;
        if ({block_picked, object_drop, EU_fault_flag, CU_fault_flag,
             RU_fault_flag, faults_serviced} !== 7'b0100001
            || obsv !== expv()) begin
            n_fail++;
            $display("FAIL m1_drop: got %b want %b", obsv, expv());
        end
        raise_fault(2'b01, LAT + 1);
        n_cmp++;
        if ({object_drop, EU_fault_flag} !== 2'b01 || obsv !== expv()) begin
            n_fail++;
            $display("FAIL m2_fault: got %b want %b", obsv, expv());
        end
        pick_done = 1; tick(); pick_done = 0;
        tick();
        drop_done = 1; tick(); drop_done = 0;
        n_cmp++;
        if ({run_complete, object_drop, faults_serviced} !== 4'b1010
            || obsv !== expv()) begin
            n_fail++;
            $display("FAIL m2_done: got %b want %b", obsv, expv());
        end
        start = 1; tick(); start = 0;
        n_cmp++;
        if ({run_complete, faults_serviced} !== 3'b000 || obsv !== expv()) begin
            n_fail++;
            $display("FAIL done_restart: got %b want %b", obsv, expv());
        end
    endtask

    task automatic test_out_of_order();
        do_reset();
        pulse_start();
        raise_fault(2'b11, LAT + 1);
        drop_done = 1; tick(); drop_done = 0;
        n_cmp++;
        if ({fault_detect, block_picked, object_drop, faults_serviced} !== 5'b10000
            || obsv !== expv()) begin
            n_fail++;
            $display("FAIL drop_in_fault: got %b want %b", obsv, expv());
        end
        pick_done = 1; drop_done = 1; tick();
        pick_done = 0; drop_done = 0;
        tick();
        n_cmp++;
        if ({fault_detect, block_picked, object_drop, RU_fault_flag,
             faults_serviced} !== 6'b010100 || obsv !== expv()) begin
            n_fail++;
            $display("FAIL pick_drop_same: got %b want %b", obsv, expv());
        end
    endtask

    task automatic test_node_retrigger();
        int space, hi, highs, rises;
        bit prev;
        space = (WIN > 1) ? 2 * DEB : 5;
        hi    = (WIN > 1) ? DEB : 2;
        do_reset();
        highs = 0;
        node_sense = 1;
        repeat (hi) tick();
        node_sense = 0;
        repeat (LAT + NH) begin
            tick();
            highs += int'(node_flag);
        end
        n_cmp++;
        if (highs != 0) begin
            n_fail++;
            $display("FAIL node_idle: got %0d high cycles want 0", highs);
        end
        pulse_start();
        repeat (WIN + 2) tick();
        highs = 0; rises = 0; prev = 0;
        for (int c = 0; c < space + NH + LAT + 10; c++) begin
            node_sense = (c < hi) || (c >= space && c < space + hi);
            tick();
            highs += int'(node_flag);
            rises += int'(node_flag & ~prev);
            prev   = node_flag;
        end
        n_cmp++;
        if (highs != space + NH || rises != 1) begin
            n_fail++;
            $display("FAIL node_retrigger: got %0d high in %0d runs want %0d in 1",
                     highs, rises, space + NH);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_start();
        raise_fault(2'b10, LAT + 1);
        pick_done = 1; tick(); pick_done = 0;
        tick();
        @(negedge clk);
        rst_n = 0;
        model_reset();
        #1;
        n_cmp++;
        if (obsv !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_async: got %b want %b", obsv, 10'b0);
        end
        @(posedge clk);
        #1 rst_n = 1;
        drop_done = 1; tick(); drop_done = 0;
        pick_done = 1; tick(); pick_done = 0;
        n_cmp++;
        if (obsv !== 10'b0 || obsv !== expv()) begin
            n_fail++;
            $display("FAIL reset_hold_idle: got %b want %b", obsv, 10'b0);
        end
        pulse_start();
        raise_fault(2'b01, LAT + 1);
        n_cmp++;
        if ({fault_detect, EU_fault_flag} !== 2'b11 || obsv !== expv()) begin
            n_fail++;
            $display("FAIL reset_restart: got %b want %b", obsv, expv());
        end
    endtask

    task automatic test_random();
        int f_left, n_left;
        do_reset();
        pulse_start();
        f_left = 0; n_left = 0;
        for (int c = 0; c < 800; c++) begin
            if (f_left == 0) begin
                fault_sense = ~fault_sense;
                f_left = $urandom_range(1, 2 * WIN + 3);
            end
            if (n_left == 0) begin
                node_sense = ~node_sense;
                n_left = $urandom_range(1, 2 * WIN + 6);
            end
            f_left--; n_left--;
            if ($urandom_range(0, 9) == 0) unit_sel = 2'($urandom_range(0, 3));
            start     = ($urandom_range(0, 39) == 0);
            pick_done = ($urandom_range(0, 5) == 0);
            drop_done = ($urandom_range(0, 5) == 0);
            tick();
            n_cmp++;
            if (obsv !== expv()
                || $countones({EU_fault_flag, CU_fault_flag, RU_fault_flag}) > 1) begin
                n_fail++;
                $display("FAIL random_c%0d: got %b want %b", c, obsv, expv());
            end
        end
        start = 0; pick_done = 0; drop_done = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_debounce_reject();
        test_fault_accept();
        test_full_mission();
        test_out_of_order();
        test_node_retrigger();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
